// File: rtl/ft245_fifo_responder.sv
// FT245-style chip-side FIFO responder: command FIFO served on RD/RXF, upload FIFO filled on WR/TXE.
// Optional loopback (macro FT245_LOOPBACK_EN) adds LPBK, routing WR bytes into the command FIFO.
module ft245_fifo_responder #(
   parameter int DEPTH_LOG2 = 6,
   parameter int RXF_HOLD   = 4,
   parameter int TXE_HOLD   = 4
) (
   input  logic                  CLK,
   input  logic                  RSTN,
`ifdef FT245_LOOPBACK_EN
   input  logic                  LPBK,
`endif
   inout  wire  [7:0]            USBX,
   input  logic                  RD,
   input  logic                  WR,
   output logic                  RXF,
   output logic                  TXE,
   input  logic [7:0]            CMD_DATA,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   output logic [7:0]            UP_DATA,
   output logic                  UP_VALID,
   input  logic                  UP_READY,
   output logic [DEPTH_LOG2:0]   CMD_LEVEL,
   output logic [DEPTH_LOG2:0]   UP_LEVEL,
   output logic                  UNDERRUN,
   output logic                  OVERRUN,
   output logic                  PROT_ERR,
   output logic [1:0]            DBG_RD_STATE
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int RHW   = $clog2(RXF_HOLD + 1);
   localparam int THW   = $clog2(TXE_HOLD + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HOLD  = 2'd2
   } rd_state_e;

   rd_state_e        state_q, state_d;
   logic             rd_q, wr_q;
   logic [7:0]       usb_q, usb_d;
   logic [RHW-1:0]   rxf_cnt_q, rxf_cnt_d;
   logic [THW-1:0]   txe_cnt_q, txe_cnt_d;
   logic             rd_prot_q, rd_prot_d;
   logic [PW-1:0]    cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
   logic [PW-1:0]    up_wp_q, up_wp_d, up_rp_q, up_rp_d;
   logic [7:0]       cmd_mem_q [DEPTH];
   logic [7:0]       up_mem_q  [DEPTH];
   logic             rxf_q, rxf_d, txe_q, txe_d;
   logic             cmd_ready_q, cmd_ready_d, up_valid_q, up_valid_d;
   logic [7:0]       up_data_q, up_data_d;
   logic [PW-1:0]    cmd_level_q, cmd_level_d, up_level_q, up_level_d;
   logic             underrun_q, underrun_d, overrun_q, overrun_d, prot_err_q, prot_err_d;

   logic             lpbk;
   logic             rd_fall, rd_rise, wr_fall, conflict;
   logic             wr_accept, wr_to_cmd, wr_to_up;
   logic             cmd_full, cmd_empty, up_full, up_empty;
   logic             cmd_push, cmd_pop, up_push, up_pop;
   logic [7:0]       cmd_push_data;
   logic             drive_en;

`ifdef FT245_LOOPBACK_EN
   assign lpbk = LPBK;
`else
   assign lpbk = 1'b0;
`endif

   function automatic logic fifo_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
      return (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
   endfunction

   assign rd_fall  = rd_q & ~RD;
   assign rd_rise  = ~rd_q & RD;
   assign wr_fall  = wr_q & ~WR;
   assign conflict = ~RD & WR;

   assign cmd_full  = fifo_full(cmd_wp_q, cmd_rp_q);
   assign cmd_empty = (cmd_wp_q == cmd_rp_q);
   assign up_full   = fifo_full(up_wp_q, up_rp_q);
   assign up_empty  = (up_wp_q == up_rp_q);

   assign wr_accept = wr_fall & ~txe_q;
   assign wr_to_cmd = wr_accept & lpbk;
   assign wr_to_up  = wr_accept & ~lpbk;

   // A loopback WR byte owns the command FIFO write port, so the host is held off that cycle.
   assign CMD_READY     = cmd_ready_q & ~wr_to_cmd;
   assign cmd_push      = ((CMD_VALID & CMD_READY) | wr_to_cmd) & ~cmd_full;
   assign cmd_push_data = wr_to_cmd ? usb_q : CMD_DATA;
   assign up_push       = wr_to_up & ~up_full;
   assign up_pop        = up_valid_q & UP_READY & ~up_empty;

   // Read state machine.
   always_comb begin
      state_d    = state_q;
      rxf_cnt_d  = rxf_cnt_q;
      rd_prot_d  = rd_prot_q | conflict;
      cmd_pop    = 1'b0;
      underrun_d = underrun_q | (rd_fall & rxf_q & (state_q != ST_DRIVE));
      case (state_q)
         ST_IDLE: begin
            if (rd_fall && !rxf_q) begin
               state_d   = ST_DRIVE;
               rd_prot_d = conflict;
            end
         end
         ST_DRIVE: begin
            if (rd_rise) begin
               cmd_pop   = ~rd_prot_q & ~cmd_empty;
               state_d   = ST_HOLD;
               rxf_cnt_d = RHW'(RXF_HOLD - 1);
            end
         end
         ST_HOLD: begin
            if (rxf_cnt_q == '0) state_d = ST_IDLE;
            else                 rxf_cnt_d = rxf_cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write path, FIFO pointers and registered status outputs.
   always_comb begin
      usb_d      = WR ? USBX : usb_q;
      txe_cnt_d  = txe_cnt_q;
      if (wr_accept)              txe_cnt_d = THW'(TXE_HOLD);
      else if (txe_cnt_q != '0)   txe_cnt_d = txe_cnt_q - 1'b1;
      overrun_d  = overrun_q | (wr_fall & txe_q);
      prot_err_d = prot_err_q | conflict;

      cmd_wp_d = cmd_wp_q + {{(PW-1){1'b0}}, cmd_push};
      cmd_rp_d = cmd_rp_q + {{(PW-1){1'b0}}, cmd_pop};
      up_wp_d  = up_wp_q  + {{(PW-1){1'b0}}, up_push};
      up_rp_d  = up_rp_q  + {{(PW-1){1'b0}}, up_pop};

      cmd_level_d = cmd_wp_d - cmd_rp_d;
      up_level_d  = up_wp_d - up_rp_d;
      cmd_ready_d = ~fifo_full(cmd_wp_d, cmd_rp_d);
      up_valid_d  = (up_wp_d != up_rp_d);
      rxf_d       = (cmd_wp_d == cmd_rp_d) | (state_d != ST_IDLE);
      txe_d       = (lpbk ? fifo_full(cmd_wp_d, cmd_rp_d) : fifo_full(up_wp_d, up_rp_d))
                    | (txe_cnt_d != '0);

      // The new head may be the byte being written this very cycle.
      if (up_push && (up_wp_q == up_rp_d)) up_data_d = usb_q;
      else                                 up_data_d = up_mem_q[up_rp_d[PW-2:0]];
   end

   always_ff @(posedge CLK) begin
      if (cmd_push) cmd_mem_q[cmd_wp_q[PW-2:0]] <= cmd_push_data;
      if (up_push)  up_mem_q[up_wp_q[PW-2:0]]   <= usb_q;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         rd_q        <= 1'b1;
         wr_q        <= 1'b0;
         usb_q       <= '0;
         rxf_cnt_q   <= '0;
         txe_cnt_q   <= '0;
         rd_prot_q   <= 1'b0;
         cmd_wp_q    <= '0;
         cmd_rp_q    <= '0;
         up_wp_q     <= '0;
         up_rp_q     <= '0;
         rxf_q       <= 1'b1;
         txe_q       <= 1'b1;
         cmd_ready_q <= 1'b0;
         up_valid_q  <= 1'b0;
         up_data_q   <= '0;
         cmd_level_q <= '0;
         up_level_q  <= '0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
         prot_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= RD;
         wr_q        <= WR;
         usb_q       <= usb_d;
         rxf_cnt_q   <= rxf_cnt_d;
         txe_cnt_q   <= txe_cnt_d;
         rd_prot_q   <= rd_prot_d;
         cmd_wp_q    <= cmd_wp_d;
         cmd_rp_q    <= cmd_rp_d;
         up_wp_q     <= up_wp_d;
         up_rp_q     <= up_rp_d;
         rxf_q       <= rxf_d;
         txe_q       <= txe_d;
         cmd_ready_q <= cmd_ready_d;
         up_valid_q  <= up_valid_d;
         up_data_q   <= up_data_d;
         cmd_level_q <= cmd_level_d;
         up_level_q  <= up_level_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
         prot_err_q  <= prot_err_d;
      end
   end

   // Bus is released the instant RD rises, WR rises (initiator wins) or reset hits.
   assign drive_en = (state_q == ST_DRIVE) & ~RD & ~WR;
   assign USBX     = drive_en ? cmd_mem_q[cmd_rp_q[PW-2:0]] : 8'hzz;

   assign RXF          = rxf_q;
   assign TXE          = txe_q;
   assign UP_DATA      = up_data_q;
   assign UP_VALID     = up_valid_q;
   assign CMD_LEVEL    = cmd_level_q;
   assign UP_LEVEL     = up_level_q;
   assign UNDERRUN     = underrun_q;
   assign OVERRUN      = overrun_q;
   assign PROT_ERR     = prot_err_q;
   assign DBG_RD_STATE = state_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Directed bench for ft245_fifo_responder: reset, reads, writes, overflow, underrun, conflict, abort.
// The bus carries a pull-up so a released USBX reads back as 8'hFF.
module tb_ft245_fifo_responder;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rd = 1'b1;
   logic       wr = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       up_ready = 1'b0;
   logic       tb_oe = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic [7:0] tb_dat = 8'h00;
   tri1  [7:0] usbx;

   logic       rxf, txe, cmd_ready, up_valid, underrun, overrun, prot_err;
   logic [7:0] up_data;
   logic [6:0] cmd_level, up_level;
   logic [1:0] dbg_state;

   logic [7:0] exp_q[$];
   int         vec_cnt = 0;
   int         err_cnt = 0;

   assign usbx = tb_oe ? tb_dat : 8'hzz;

   ft245_fifo_responder dut (
      .CLK          (clk),
      .RSTN         (rstn),
`ifdef FT245_LOOPBACK_EN
      .LPBK         (1'b0),
`endif
      .USBX         (usbx),
      .RD           (rd),
      .WR           (wr),
      .RXF          (rxf),
      .TXE          (txe),
      .CMD_DATA     (cmd_data),
      .CMD_VALID    (cmd_valid),
      .CMD_READY    (cmd_ready),
      .UP_DATA      (up_data),
      .UP_VALID     (up_valid),
      .UP_READY     (up_ready),
      .CMD_LEVEL    (cmd_level),
      .UP_LEVEL     (up_level),
      .UNDERRUN     (underrun),
      .OVERRUN      (overrun),
      .PROT_ERR     (prot_err),
      .DBG_RD_STATE (dbg_state)
   );

   // Clock and reset; inputs change and outputs are sampled just after the falling edge.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_cmd(input logic [7:0] d);
      cmd_data  = d;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_read(input int low_cycles, output logic [7:0] got);
      rd = 1'b0;
      tick();
      got = usbx;
      repeat (low_cycles - 1) tick();
      rd = 1'b1;
      tick();
   endtask

   task automatic wr_pulse(input logic [7:0] d);
      tb_oe  = 1'b1;
      tb_dat = d;
      wr     = 1'b1;
      tick();
      wr    = 1'b0;
      tb_oe = 1'b0;
      tick();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL reset_rxf: got %b exp 1", rxf); end
      vec_cnt++; if (txe !== 1'b1) begin err_cnt++; $display("FAIL reset_txe: got %b exp 1", txe); end
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL reset_usbx: got %h exp FF (released)", usbx); end
      vec_cnt++; if (cmd_level !== 7'd0) begin err_cnt++; $display("FAIL reset_cmd_level: got %0d exp 0", cmd_level); end
      vec_cnt++; if (up_level !== 7'd0) begin err_cnt++; $display("FAIL reset_up_level: got %0d exp 0", up_level); end
      vec_cnt++; if ({underrun, overrun, prot_err} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b exp 000", {underrun, overrun, prot_err}); end
      vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
      vec_cnt++; if (up_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_up_valid: got %b exp 0", up_valid); end
      vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
      rstn = 1'b1;
      tick();
      vec_cnt++; if (txe !== 1'b0) begin err_cnt++; $display("FAIL release_txe: got %b exp 0", txe); end
      vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL release_cmd_ready: got %b exp 1", cmd_ready); end
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL release_rxf: got %b exp 1", rxf); end
   endtask

   task automatic test_single_read();
      push_cmd(8'h07);
      vec_cnt++; if (rxf !== 1'b0) begin err_cnt++; $display("FAIL single_rxf_low: got %b exp 0", rxf); end
      vec_cnt++; if (cmd_level !== 7'd1) begin err_cnt++; $display("FAIL single_level1: got %0d exp 1", cmd_level); end
      rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         vec_cnt++; if (usbx !== 8'h07) begin err_cnt++; $display("FAIL single_usbx_c%0d: got %h exp 07", i, usbx); end
      end
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL single_rxf_drive: got %b exp 1", rxf); end
      rd = 1'b1;
      tick();
      vec_cnt++; if (cmd_level !== 7'd0) begin err_cnt++; $display("FAIL single_level0: got %0d exp 0", cmd_level); end
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL single_release: got %h exp FF", usbx); end
      repeat (5) tick();
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL single_rxf_empty: got %b exp 1", rxf); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      int         n;
      push_cmd(8'h05);
      push_cmd(8'h08);
      vec_cnt++; if (cmd_level !== 7'd2) begin err_cnt++; $display("FAIL b2b_level: got %0d exp 2", cmd_level); end
      vec_cnt++; if (rxf !== 1'b0) begin err_cnt++; $display("FAIL b2b_rxf: got %b exp 0", rxf); end
      do_read(3, got);
      vec_cnt++; if (got !== 8'h05) begin err_cnt++; $display("FAIL b2b_first: got %h exp 05", got); end
      n = (rxf === 1'b1) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rxf !== 1'b1) break;
         n++;
      end
      vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL b2b_rxf_hold: got %0d cycles exp 4", n); end
      do_read(3, got);
      vec_cnt++; if (got !== 8'h08) begin err_cnt++; $display("FAIL b2b_second: got %h exp 08", got); end
      repeat (5) tick();
      vec_cnt++; if (cmd_level !== 7'd0) begin err_cnt++; $display("FAIL b2b_empty: got %0d exp 0", cmd_level); end
   endtask

   task automatic test_write();
      int n;
      tb_oe  = 1'b1;
      tb_dat = 8'hA5;
      wr     = 1'b1;
      repeat (4) tick();
      wr    = 1'b0;
      tb_oe = 1'b0;
      tick();
      vec_cnt++; if (up_valid !== 1'b1) begin err_cnt++; $display("FAIL write_valid: got %b exp 1", up_valid); end
      vec_cnt++; if (up_data !== 8'hA5) begin err_cnt++; $display("FAIL write_data: got %h exp A5", up_data); end
      vec_cnt++; if (up_level !== 7'd1) begin err_cnt++; $display("FAIL write_level: got %0d exp 1", up_level); end
      n = (txe === 1'b1) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (txe !== 1'b1) break;
         n++;
      end
      vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL write_txe_hold: got %0d cycles exp 4", n); end
      up_ready = 1'b1;
      tick();
      up_ready = 1'b0;
      vec_cnt++; if (up_level !== 7'd0) begin err_cnt++; $display("FAIL write_drain: got %0d exp 0", up_level); end
      vec_cnt++; if (up_valid !== 1'b0) begin err_cnt++; $display("FAIL write_valid0: got %b exp 0", up_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] d;
      logic [7:0] e;
      int         guard;
      for (int i = 0; i < 64; i++) begin
         d = 8'(i * 7 + 3);
         exp_q.push_back(d);
         wr_pulse(d);
      end
      vec_cnt++; if (up_level !== 7'd64) begin err_cnt++; $display("FAIL ovf_level64: got %0d exp 64", up_level); end
      vec_cnt++; if (txe !== 1'b1) begin err_cnt++; $display("FAIL ovf_txe_full: got %b exp 1", txe); end
      vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovf_pre_overrun: got %b exp 0", overrun); end
      wr_pulse(8'hEE);
      vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovf_overrun: got %b exp 1", overrun); end
      vec_cnt++; if (up_level !== 7'd64) begin err_cnt++; $display("FAIL ovf_level_kept: got %0d exp 64", up_level); end
      up_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         e = exp_q.pop_front();
         vec_cnt++;
         if (up_valid !== 1'b1 || up_data !== e) begin
            err_cnt++;
            $display("FAIL ovf_drain_%0d: got valid=%b data=%h exp valid=1 data=%h", guard, up_valid, up_data, e);
         end
         tick();
         guard++;
      end
      up_ready = 1'b0;
      vec_cnt++; if (up_level !== 7'd0) begin err_cnt++; $display("FAIL ovf_drained: got %0d exp 0", up_level); end
      vec_cnt++; if (txe !== 1'b0) begin err_cnt++; $display("FAIL ovf_txe_free: got %b exp 0", txe); end
   endtask

   task automatic test_underrun();
      rd = 1'b0;
      tick();
      vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL underrun_flag: got %b exp 1", underrun); end
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL underrun_usbx: got %h exp FF", usbx); end
      tick();
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL underrun_usbx2: got %h exp FF", usbx); end
      rd = 1'b1;
      tick();
      vec_cnt++; if (cmd_level !== 7'd0) begin err_cnt++; $display("FAIL underrun_level: got %0d exp 0", cmd_level); end
   endtask

   task automatic test_prot_err();
      push_cmd(8'h3C);
      rd = 1'b0;
      tick();
      vec_cnt++; if (usbx !== 8'h3C) begin err_cnt++; $display("FAIL prot_drive: got %h exp 3C", usbx); end
      wr = 1'b1;
      #1;
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL prot_release: got %h exp FF", usbx); end
      tick();
      vec_cnt++; if (prot_err !== 1'b1) begin err_cnt++; $display("FAIL prot_flag: got %b exp 1", prot_err); end
      wr = 1'b0;
      tick();
      vec_cnt++; if (usbx !== 8'h3C) begin err_cnt++; $display("FAIL prot_redrive: got %h exp 3C", usbx); end
      rd = 1'b1;
      tick();
      vec_cnt++; if (cmd_level !== 7'd1) begin err_cnt++; $display("FAIL prot_no_pop: got %0d exp 1", cmd_level); end
      vec_cnt++; if (up_level !== 7'd1) begin err_cnt++; $display("FAIL prot_wr_push: got %0d exp 1", up_level); end
      repeat (5) tick();
      vec_cnt++; if (rxf !== 1'b0) begin err_cnt++; $display("FAIL prot_rxf_back: got %b exp 0", rxf); end
      up_ready = 1'b1;
      tick();
      up_ready = 1'b0;
      vec_cnt++; if (up_level !== 7'd0) begin err_cnt++; $display("FAIL prot_up_drain: got %0d exp 0", up_level); end
   endtask

   task automatic test_reset_abort();
      rd = 1'b0;
      tick();
      vec_cnt++; if (usbx !== 8'h3C) begin err_cnt++; $display("FAIL abort_drive: got %h exp 3C", usbx); end
      rstn = 1'b0;
      #1;
      vec_cnt++; if (usbx !== 8'hFF) begin err_cnt++; $display("FAIL abort_release: got %h exp FF", usbx); end
      vec_cnt++; if (cmd_level !== 7'd0) begin err_cnt++; $display("FAIL abort_level: got %0d exp 0", cmd_level); end
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL abort_rxf: got %b exp 1", rxf); end
      rd = 1'b1;
      tick();
      rstn = 1'b1;
      tick();
      vec_cnt++; if (txe !== 1'b0) begin err_cnt++; $display("FAIL abort_txe: got %b exp 0", txe); end
      vec_cnt++; if ({underrun, overrun, prot_err} !== 3'b000) begin err_cnt++; $display("FAIL abort_flags: got %b exp 000", {underrun, overrun, prot_err}); end
      vec_cnt++; if (rxf !== 1'b1) begin err_cnt++; $display("FAIL abort_rxf_after: got %b exp 1", rxf); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write();
      test_overflow();
      test_underrun();
      test_prot_err();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
